// File: rtl/alu_pkg.sv
// Shared types for alu_stream_core: opcode map, FSM states, flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NAND = 4'h5,
    OP_NOR  = 4'h6,
    OP_XNOR = 4'h7,
    OP_NOT  = 4'h8,
    OP_INC  = 4'h9,
    OP_DEC  = 4'hA,
    OP_SLL  = 4'hB,
    OP_SRL  = 4'hC,
    OP_ROL  = 4'hD,
    OP_ROR  = 4'hE,
    OP_MUL  = 4'hF
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
    logic parity;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // Load on start, then add/shift once per cycle; done pulses after the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        acc     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_stream_core.sv
// Streaming ALU with valid/ready on both sides and a held output register.
// Optional feature macro: ALU_MUL_EN (multi-cycle shift-add MUL on op F).
module alu_stream_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             parity,
  output logic             overflow,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e       state;
  alu_flags_t       flags_q;
  logic             accept;
  logic             mul_go;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  alu_flags_t       mul_flags;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, diff, sll_ext, srl_ext;
  logic [2*WIDTH-1:0] rol_ext, ror_ext;
  logic [WIDTH-1:0]   alu_res;
  alu_flags_t         alu_flags;

  assign in_ready = ~reset & (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Single-cycle op decode; the extended shifts expose the last bit shifted out
  // as carry and naturally give a/carry 0 when sh is 0.
  always_comb begin
    sh      = b[SHW-1:0];
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    sll_ext = {1'b0, a} << sh;
    srl_ext = {a, 1'b0} >> sh;
    rol_ext = {a, a} << sh;
    ror_ext = {a, a} >> sh;
    alu_res = '0;
    alu_flags = '0;
    case (alu_op_e'(op))
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_flags.carry = sum[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_flags.carry = ~diff[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_XNOR: alu_res = ~(a ^ b);
      OP_NOT:  alu_res = ~a;
      OP_INC: begin
        alu_res = a + ONE;
        alu_flags.carry = (a == '1);
        alu_flags.overflow = (a == MAXPOS);
      end
      OP_DEC: begin
        alu_res = a - ONE;
        alu_flags.carry = (a == '0);
        alu_flags.overflow = (a == MINNEG);
      end
      OP_SLL: begin
        alu_res = sll_ext[WIDTH-1:0];
        alu_flags.carry = sll_ext[WIDTH];
      end
      OP_SRL: begin
        alu_res = srl_ext[WIDTH:1];
        alu_flags.carry = srl_ext[0];
      end
      OP_ROL: begin
        alu_res = rol_ext[2*WIDTH-1:WIDTH];
        alu_flags.carry = sll_ext[WIDTH];
      end
      OP_ROR: begin
        alu_res = ror_ext[WIDTH-1:0];
        alu_flags.carry = srl_ext[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags.zero   = (alu_res == '0);
    alu_flags.sign   = alu_res[WIDTH-1];
    alu_flags.parity = ~^alu_res;
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_product;

  assign mul_go = accept & (alu_op_e'(op) == OP_MUL);
  assign busy   = (state == MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_go),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Flags for a completed multiply: carry/overflow flag a non-zero high half.
  always_comb begin
    mul_res            = mul_product[WIDTH-1:0];
    mul_flags          = '0;
    mul_flags.carry    = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags.overflow = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags.zero     = (mul_res == '0);
    mul_flags.sign     = mul_res[WIDTH-1];
    mul_flags.parity   = ~^mul_res;
  end
`else
  assign mul_go    = 1'b0;
  assign busy      = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_flags = '0;
`endif

  // Control FSM and output hold register; a transfer and a new load on the
  // same edge leave out_valid high with the new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mul_go) begin
              state <= MUL;
            end else begin
              result    <= alu_res;
              flags_q   <= alu_flags;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            result    <= mul_res;
            flags_q   <= mul_flags;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign carry    = flags_q.carry;
  assign zero     = flags_q.zero;
  assign sign     = flags_q.sign;
  assign parity   = flags_q.parity;
  assign overflow = flags_q.overflow;

endmodule
